// File: rtl/risk_tile_dma.sv
// Tile sequencer in front of the RISK strided memory: one command becomes a stream of 4x4 tile loads or stores.
// Latency: load tile appears on rd_* MEM_LAT+1 cycles after its address is driven; store reaches mem_we 3 cycles after accept.
// Backpressure: loads are credit-limited by a FIFO_DEP skid FIFO (issue stalls at zero credits); stores use wr_valid/wr_ready.
//
// Ports: clk/reset (async, active-high); cmd_* command handshake and fields; wr_* store tile input;
// rd_* load tile output; done/err one-cycle completion/rejection pulses; mem_* registered memory
// interface (addr, strides, write data, write enable) plus mem_dat_r read data return.
module risk_tile_dma #(
    parameter int MEM_LAT  = 4,
    parameter int FIFO_DEP = 4,
    parameter int NBANK    = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         cmd_store,
    input  logic [14:0]  cmd_base,
    input  logic [13:0]  cmd_sx,
    input  logic [13:0]  cmd_sy,
    input  logic [14:0]  cmd_step,
    input  logic [7:0]   cmd_count,
    input  logic         wr_valid,
    output logic         wr_ready,
    input  logic [287:0] wr_data,
    output logic         rd_valid,
    input  logic         rd_ready,
    output logic [287:0] rd_data,
    output logic         done,
    output logic         err,
    output logic [14:0]  mem_addr,
    output logic [13:0]  mem_stride_x,
    output logic [13:0]  mem_stride_y,
    output logic [287:0] mem_dat_w,
    output logic         mem_we,
    input  logic [287:0] mem_dat_r
);

    localparam int BW = $clog2(NBANK);
    localparam int CW = $clog2(FIFO_DEP + 1);
    localparam int PW = (FIFO_DEP > 1) ? $clog2(FIFO_DEP) : 1;

    typedef enum logic [2:0] {IDLE, CHECK, LOAD, STORE, DRAIN} state_t;

    state_t         state, state_nxt;
    logic           store_q;
    logic [14:0]    cur, step_q;
    logic [7:0]     count_q, issued;
    logic           issue, accept, pop, capture, quiet, conflict;
    logic [CW-1:0]  credits;
    logic [MEM_LAT:0] ld_pipe;
    logic           st_v1, st_v2;
    logic [287:0]   st_d1;

    logic [287:0]   fifo_mem [FIFO_DEP];
    logic [PW-1:0]  wp, rp;
    logic [CW-1:0]  fifo_cnt;

    // Bank of every element in the tile under the latched strides; any repeat is a conflict.
    logic [15:0][BW-1:0] bank;
    always_comb begin
        bank = '0;
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 4; x++) begin
                bank[y*4+x] = mem_stride_x[BW-1:0] * BW'(x) + mem_stride_y[BW-1:0] * BW'(y);
            end
        end
    end

    always_comb begin
        conflict = 1'b0;
        for (int i = 0; i < 16; i++) begin
            for (int j = i + 1; j < 16; j++) begin
                if (bank[i] == bank[j]) conflict = 1'b1;
            end
        end
    end

    assign rd_valid = (fifo_cnt != '0);
    assign rd_data  = fifo_mem[rp];
    assign pop      = rd_valid && rd_ready;
    // Data for an issue is on mem_dat_r while its marker sits in the last pipe stage.
    assign capture  = ld_pipe[MEM_LAT];
    // Nothing left in either pipeline: safe to report completion and to start a new command.
    assign quiet    = !st_v1 && !st_v2 && !mem_we && (ld_pipe == '0) && (fifo_cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        issue     = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nxt = CHECK;
            end
            CHECK: begin
                if (conflict) begin
                    err       = 1'b1;
                    state_nxt = IDLE;
                end else if (count_q == 8'd0) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = store_q ? STORE : LOAD;
                end
            end
            LOAD: begin
                if (credits != '0) begin
                    issue = 1'b1;
                    if (issued == count_q - 8'd1) state_nxt = DRAIN;
                end
            end
            STORE: begin
                wr_ready = (issued < count_q);
                accept   = wr_valid && wr_ready;
                if (accept && (issued == count_q - 8'd1)) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (quiet) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            store_q      <= 1'b0;
            cur          <= '0;
            step_q       <= '0;
            count_q      <= '0;
            issued       <= '0;
            mem_addr     <= '0;
            mem_stride_x <= '0;
            mem_stride_y <= '0;
            mem_dat_w    <= '0;
            mem_we       <= 1'b0;
            st_v1        <= 1'b0;
            st_v2        <= 1'b0;
            st_d1        <= '0;
            ld_pipe      <= '0;
            credits      <= CW'(FIFO_DEP);
        end else begin
            if (state == IDLE && cmd_valid) begin
                store_q      <= cmd_store;
                cur          <= cmd_base;
                step_q       <= cmd_step;
                count_q      <= cmd_count;
                issued       <= '0;
                mem_stride_x <= cmd_sx;
                mem_stride_y <= cmd_sy;
            end
            // Loads and stores share the address walk; only one kind runs per command.
            if (issue || accept) begin
                mem_addr <= cur;
                cur      <= cur + step_q;
                issued   <= issued + 8'd1;
            end
            // Store pipeline: addr at t+1, data at t+2, write strobe at t+3.
            st_v1 <= accept;
            if (accept) st_d1 <= wr_data;
            st_v2 <= st_v1;
            if (st_v1) mem_dat_w <= st_d1;
            mem_we <= st_v2;
            ld_pipe <= {ld_pipe[MEM_LAT-1:0], issue};
            case ({issue, pop})
                2'b10:   credits <= credits - CW'(1);
                2'b01:   credits <= credits + CW'(1);
                default: credits <= credits;
            endcase
        end
    end

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEP - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp       <= '0;
            rp       <= '0;
            fifo_cnt <= '0;
        end else begin
            if (capture) wp <= ptr_inc(wp);
            if (pop)     rp <= ptr_inc(rp);
            case ({capture, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (capture) fifo_mem[wp] <= mem_dat_r;
    end

endmodule

// File: tb/tb_risk_tile_dma.sv
// Directed bench for risk_tile_dma with a fixed-latency memory model.
// Latency: memory returns pattern(addr) four cycles after the address is presented.
// Backpressure: rd_ready and wr_valid are driven per test to exercise stalls and gaps.
module tb_risk_tile_dma;

    logic         clk;
    logic         reset;
    logic         cmd_valid, cmd_ready, cmd_store;
    logic [14:0]  cmd_base, cmd_step;
    logic [13:0]  cmd_sx, cmd_sy;
    logic [7:0]   cmd_count;
    logic         wr_valid, wr_ready;
    logic [287:0] wr_data;
    logic         rd_valid, rd_ready;
    logic [287:0] rd_data;
    logic         done, err;
    logic [14:0]  mem_addr;
    logic [13:0]  mem_stride_x, mem_stride_y;
    logic [287:0] mem_dat_w;
    logic         mem_we;
    logic [287:0] mem_dat_r;

    int n_chk;
    int n_pass;
    int addr_chg;
    int we_cnt;
    int rv_cnt;
    logic [14:0] last_addr;
    logic [14:0] ap [4];

    risk_tile_dma dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_store(cmd_store),
        .cmd_base(cmd_base), .cmd_sx(cmd_sx), .cmd_sy(cmd_sy),
        .cmd_step(cmd_step), .cmd_count(cmd_count),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .done(done), .err(err),
        .mem_addr(mem_addr), .mem_stride_x(mem_stride_x), .mem_stride_y(mem_stride_y),
        .mem_dat_w(mem_dat_w), .mem_we(mem_we), .mem_dat_r(mem_dat_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [287:0] pat(input logic [14:0] a);
        logic [287:0] r;
        r = '0;
        for (int e = 0; e < 16; e++) r[18*e +: 18] = {a[13:0], 4'(e)};
        return r;
    endfunction

    function automatic logic [287:0] wpat(input int i);
        logic [287:0] r;
        r = '0;
        for (int e = 0; e < 16; e++) r[18*e +: 18] = 18'(32'h20000 + i * 16 + e);
        return r;
    endfunction

    // Memory model: address seen in cycle A yields data during cycle A+4.
    always @(posedge clk) begin
        ap[0] <= mem_addr;
        ap[1] <= ap[0];
        ap[2] <= ap[1];
        ap[3] <= ap[2];
    end
    assign mem_dat_r = pat(ap[3]);

    // Free-running activity counters; tests look at deltas.
    always @(negedge clk) begin
        if (mem_addr !== last_addr) addr_chg <= addr_chg + 1;
        last_addr <= mem_addr;
        if (mem_we === 1'b1) we_cnt <= we_cnt + 1;
        if (rd_valid === 1'b1) rv_cnt <= rv_cnt + 1;
    end

    task automatic check(input string tag, input logic [287:0] got, input logic [287:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns in the CHECK cycle of the command.
    task automatic send_cmd(input logic st, input logic [14:0] base, input logic [13:0] sx,
                            input logic [13:0] sy, input logic [14:0] step, input logic [7:0] cnt);
        int w;
        cmd_store = st; cmd_base = base; cmd_sx = sx; cmd_sy = sy;
        cmd_step = step; cmd_count = cnt; cmd_valid = 1'b1;
        w = 0;
        while (!cmd_ready && w < 50) begin
            tick();
            w++;
        end
        check("cmd_ready", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0;
    endtask

    // Pops load tiles until done, comparing each against the expected address walk.
    task automatic collect(input logic [14:0] base, input logic [14:0] step, input int cnt,
                           input string tag);
        int n;
        bit seen;
        logic [14:0] a;
        n = 0;
        seen = 1'b0;
        a = base;
        for (int c = 0; c < 300 && !seen; c++) begin
            if (rd_valid && rd_ready) begin
                check(tag, rd_data, pat(a));
                a = a + step;
                n++;
            end
            if (done) seen = 1'b1;
            else tick();
        end
        check({tag, "_count"}, n, cnt);
        check({tag, "_done"}, seen, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int s_ad, s_we;
        bit seen;
        n_chk = 0; n_pass = 0;
        cmd_valid = 0; cmd_store = 0; cmd_base = '0; cmd_sx = '0; cmd_sy = '0;
        cmd_step = '0; cmd_count = '0; wr_valid = 0; wr_data = '0; rd_ready = 0;
        reset = 1'b0;
        #1 reset = 1'b1;
        #2;
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_wr_ready", wr_ready, 1'b0);
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 15'h0);
        check("rst_mem_dat_w", mem_dat_w, 288'h0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Single-tile load
        rd_ready = 1'b1;
        s_ad = addr_chg;
        send_cmd(1'b0, 15'h0040, 14'd1, 14'd4, 15'h0020, 8'd1);
        check("t1_err", err, 1'b0);
        tick(); tick();
        check("t1_addr", mem_addr, 15'h0040);
        check("t1_we", mem_we, 1'b0);
        tick(); tick(); tick(); tick();
        check("t1_rd_early", rd_valid, 1'b0);
        tick();
        check("t1_rd_valid", rd_valid, 1'b1);
        check("t1_rd_data", rd_data, pat(15'h0040));
        tick();
        check("t1_done", done, 1'b1);
        tick();
        check("t1_done_pulse", done, 1'b0);
        check("t1_idle", cmd_ready, 1'b1);
        check("t1_addr_once", addr_chg - s_ad, 1);

        // Bank conflicts rejected
        s_ad = addr_chg;
        send_cmd(1'b0, 15'h0100, 14'd8, 14'd16, 15'h0020, 8'd2);
        check("t2_err", err, 1'b1);
        check("t2_done", done, 1'b0);
        tick();
        check("t2_idle", cmd_ready, 1'b1);
        check("t2_err_pulse", err, 1'b0);
        send_cmd(1'b0, 15'h0100, 14'd0, 14'd1, 15'h0020, 8'd1);
        check("t2_err_sx0", err, 1'b1);
        tick(); tick();
        check("t2_no_traffic", addr_chg - s_ad, 0);
        check("t2_addr_held", mem_addr, 15'h0040);

        // Three back-to-back stores
        s_we = we_cnt;
        send_cmd(1'b1, 15'h0000, 14'd1, 14'd4, 15'h0020, 8'd3);
        wr_valid = 1'b1;
        wr_data = wpat(0);
        tick();
        check("t3_wr_ready", wr_ready, 1'b1);
        check("t3_stride_x", mem_stride_x, 14'd1);
        check("t3_stride_y", mem_stride_y, 14'd4);
        tick();
        wr_data = wpat(1);
        check("t3_addr0", mem_addr, 15'h0000);
        check("t3_we_c3", mem_we, 1'b0);
        tick();
        wr_data = wpat(2);
        check("t3_addr1", mem_addr, 15'h0020);
        check("t3_dat0", mem_dat_w, wpat(0));
        check("t3_we_c4", mem_we, 1'b0);
        tick();
        wr_valid = 1'b0;
        check("t3_addr2", mem_addr, 15'h0040);
        check("t3_dat1", mem_dat_w, wpat(1));
        check("t3_we0", mem_we, 1'b1);
        check("t3_wr_ready_off", wr_ready, 1'b0);
        tick();
        check("t3_dat2", mem_dat_w, wpat(2));
        check("t3_we1", mem_we, 1'b1);
        tick();
        check("t3_we2", mem_we, 1'b1);
        check("t3_done_early", done, 1'b0);
        tick();
        check("t3_we_end", mem_we, 1'b0);
        check("t3_done", done, 1'b1);
        tick();
        check("t3_idle", cmd_ready, 1'b1);
        check("t3_we_count", we_cnt - s_we, 3);

        // Stores with wr_valid gaps
        s_we = we_cnt;
        send_cmd(1'b1, 15'h0100, 14'd1, 14'd4, 15'h0008, 8'd2);
        seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            wr_valid = (c % 2 == 0);
            wr_data = wpat(c);
            if (done) seen = 1'b1;
            else tick();
        end
        wr_valid = 1'b0;
        check("t3b_done", seen, 1'b1);
        check("t3b_we_count", we_cnt - s_we, 2);
        check("t3b_last_addr", mem_addr, 15'h0108);
        tick();

        // Load with consumer stalled: credits cap issues at the FIFO depth
        rd_ready = 1'b0;
        s_ad = addr_chg;
        s_we = we_cnt;
        send_cmd(1'b0, 15'h0100, 14'd1, 14'd4, 15'h0010, 8'd10);
        repeat (20) tick();
        check("t4_stall_issues", addr_chg - s_ad, 4);
        check("t4_rd_valid", rd_valid, 1'b1);
        rd_ready = 1'b1;
        collect(15'h0100, 15'h0010, 10, "t4_tile");
        check("t4_all_issues", addr_chg - s_ad, 10);
        check("t4_no_we", we_cnt - s_we, 0);
        tick();

        // Address wrap
        send_cmd(1'b0, 15'h7FF0, 14'd1, 14'd4, 15'h0020, 8'd2);
        tick(); tick();
        check("t5_addr0", mem_addr, 15'h7FF0);
        tick();
        check("t5_addr_wrap", mem_addr, 15'h0010);
        collect(15'h7FF0, 15'h0020, 2, "t5_tile");
        tick();

        // Zero count (large strides reduce to a legal pattern)
        s_ad = addr_chg;
        s_we = we_cnt;
        send_cmd(1'b0, 15'h0300, 14'd33, 14'd4, 15'h0001, 8'd0);
        check("t6_done", done, 1'b1);
        check("t6_err", err, 1'b0);
        tick();
        check("t6_done_pulse", done, 1'b0);
        check("t6_idle", cmd_ready, 1'b1);
        tick(); tick(); tick();
        check("t6_no_addr", addr_chg - s_ad, 0);
        check("t6_no_we", we_cnt - s_we, 0);

        // Reset in the middle of a load
        rd_ready = 1'b0;
        send_cmd(1'b0, 15'h0200, 14'd1, 14'd4, 15'h0010, 8'd10);
        repeat (8) tick();
        check("t7_pre_rd_valid", rd_valid, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("t7_rd_valid", rd_valid, 1'b0);
        check("t7_cmd_ready", cmd_ready, 1'b1);
        check("t7_wr_ready", wr_ready, 1'b0);
        check("t7_mem_addr", mem_addr, 15'h0);
        check("t7_mem_we", mem_we, 1'b0);
        check("t7_mem_dat_w", mem_dat_w, 288'h0);
        check("t7_stride_x", mem_stride_x, 14'd0);
        check("t7_done", done, 1'b0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        rd_ready = 1'b1;
        tick();
        s_ad = rv_cnt;
        repeat (12) tick();
        check("t7_no_late_rd", rv_cnt - s_ad, 0);
        check("t7_idle", cmd_ready, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
